// File: rtl/main_mem_pkg.sv
// Shared constants for the main-memory block: bus region codes, FSM encoding
// and the reset-time memory image.
package main_mem_pkg;

  // Bus regions, decoded from address[15:12]
  localparam logic [3:0] REGION_ROM  = 4'h0;
  localparam logic [3:0] REGION_IO   = 4'h1;
  localparam logic [3:0] MAIN_MEM_EN = 4'h2;
  localparam logic [3:0] REGION_GPU  = 4'h3;

  // FSM encodings kept as plain constants so older code can compare raw bits
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_BURST = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    RD_BURST = ST_RD_BURST,
    WR_BURST = ST_WR_BURST
  } mem_state_e;

  // Width of the image words; the top truncates or zero-extends to DATA_W
  localparam int INIT_W = 256;

  // Operand matrices, 16 packed 16-bit elements each (element 0 in the LSBs)
  localparam logic [INIT_W-1:0] MAT_A =
    256'h000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [INIT_W-1:0] MAT_B =
    256'h0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002_0002;

  // Reset-time image; unlisted entries are zero
  function automatic logic [INIT_W-1:0] main_mem_init(input int idx);
    case (idx)
      0:       return MAT_A;
      1:       return MAT_B;
      10:      return INIT_W'(6);
      11:      return INIT_W'(13);
      default: return '0;
    endcase
  endfunction

  // Width of the BurstLen field; never zero even for single-beat configs
  function automatic int bl_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/main_memory_burst_if.sv
// CPU-side bus of the main memory: request strobes, burst length, data and
// the Busy/DataValid/AddrErr status returned by the memory.
interface main_memory_burst_if
  import main_mem_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 4
);
  localparam int BL_W = bl_width(MAX_BURST);

  logic [15:0]       address;
  logic [DATA_W-1:0] DataIn;
  logic              nRead;
  logic              nWrite;
  logic [BL_W-1:0]   BurstLen;
  logic [DATA_W-1:0] Dataout;
  logic              DataValid;
  logic              Busy;
  logic              AddrErr;

  modport master (
    output address, DataIn, nRead, nWrite, BurstLen,
    input  Dataout, DataValid, Busy, AddrErr
  );

  modport slave (
    input  address, DataIn, nRead, nWrite, BurstLen,
    output Dataout, DataValid, Busy, AddrErr
  );
endinterface

// File: rtl/main_mem_burst_seq.sv
// Burst sequencer: tracks the remaining beats of an accepted burst and
// produces the wrapped word address for each follow-on beat.
module main_mem_burst_seq
  import main_mem_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int MAX_BURST = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int BL_W      = bl_width(MAX_BURST)
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            i_rd_start,
  input  logic            i_wr_start,
  input  logic [AW-1:0]   i_idx,
  input  logic [BL_W-1:0] i_len,
  output logic            o_busy,
  output logic            o_rd_beat,
  output logic            o_wr_beat,
  output logic [AW-1:0]   o_beat_addr
);

  mem_state_e      r_state;
  logic [AW-1:0]   r_addr;
  logic [BL_W-1:0] r_beat;
  logic [BL_W-1:0] r_len;

  // Next index modulo DEPTH, so DEPTH-1 is followed by 0 for any DEPTH
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Burst FSM: beat 0 happens at acceptance in IDLE, beats 1..len here
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((i_rd_start || i_wr_start) && (i_len != '0)) begin
            r_state <= i_rd_start ? RD_BURST : WR_BURST;
            r_addr  <= wrap_inc(i_idx);
            r_beat  <= BL_W'(1);
            r_len   <= i_len;
          end
        end
        RD_BURST, WR_BURST: begin
          r_addr <= wrap_inc(r_addr);
          if (r_beat == r_len) begin
            r_state <= IDLE;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + BL_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_rd_beat   = (r_state == RD_BURST);
  assign o_wr_beat   = (r_state == WR_BURST);
  assign o_beat_addr = r_addr;

endmodule

// File: rtl/main_memory_burst.sv
// Main memory with reset-loaded image, range-checked single/burst access,
// read-modify-write on simultaneous strobes and wrapped burst addressing.
module main_memory_burst
  import main_mem_pkg::*;
#(
  parameter int         DATA_W    = 256,
  parameter int         DEPTH     = 16,
  parameter logic [3:0] REGION_ID = MAIN_MEM_EN,
  parameter int         MAX_BURST = 4
) (
  input logic                Clk,
  input logic                nReset,
  main_memory_burst_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_err;

  logic          w_busy, w_seq_rd, w_seq_wr;
  logic          w_take, w_in_range, w_ok, w_rd, w_wr;
  logic [AW-1:0] w_idx, w_seq_addr;

  // Request decode: only an idle, selected, strobed cycle is considered
  assign w_take     = !w_busy && (bus.address[15:12] == REGION_ID)
                      && (!bus.nRead || !bus.nWrite);
  assign w_in_range = ({1'b0, bus.address[11:0]} < DEPTH_L);
  assign w_ok       = w_take && w_in_range;
  assign w_rd       = w_ok && !bus.nRead;
  assign w_wr       = w_ok && !bus.nWrite;
  // Index is narrowed only after the range check has seen all 12 bits
  assign w_idx      = bus.address[AW-1:0];

  main_mem_burst_seq #(
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) u_seq (
    .Clk         (Clk),
    .nReset      (nReset),
    .i_rd_start  (w_rd && bus.nWrite),
    .i_wr_start  (w_wr && bus.nRead),
    .i_idx       (w_idx),
    .i_len       (bus.BurstLen),
    .o_busy      (w_busy),
    .o_rd_beat   (w_seq_rd),
    .o_wr_beat   (w_seq_wr),
    .o_beat_addr (w_seq_addr)
  );

  // Storage and output registers; reads sample the pre-write word (RMW)
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      // NOTE: the array sits in the reset branch on purpose so reset reloads
      // the image; this makes it flops rather than an inferred RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(main_mem_init(i));
      end
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the RMW read below sees the old
      // word even though the same edge writes it.
      r_valid <= 1'b0;
      r_err   <= w_take && !w_in_range;
      if (w_rd) begin
        r_dout  <= r_mem[w_idx];
        r_valid <= 1'b1;
      end
      if (w_seq_rd) begin
        r_dout  <= r_mem[w_seq_addr];
        r_valid <= 1'b1;
      end
      if (w_wr) begin
        r_mem[w_idx] <= bus.DataIn;
      end
      if (w_seq_wr) begin
        r_mem[w_seq_addr] <= bus.DataIn;
      end
    end
  end

  assign bus.Dataout   = r_dout;
  assign bus.DataValid = r_valid;
  assign bus.Busy      = w_busy;
  assign bus.AddrErr   = r_err;

endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench for main_memory_burst. Stimulus pushes expected read data
// into a queue; a monitor pops and compares on every DataValid beat.
module tb_main_memory_burst;
  import main_mem_pkg::*;

  localparam logic [3:0] REG = MAIN_MEM_EN;

  localparam logic [255:0] WA = {16{16'hA5A1}};
  localparam logic [255:0] WB = {16{16'hB6B2}};
  localparam logic [255:0] WC = {16{16'hC7C3}};
  localparam logic [255:0] WD = {16{16'hD8D4}};

  logic Clk = 1'b1;
  logic nReset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [255:0] exp_q [$];

  always #5 Clk = ~Clk;

  main_memory_burst_if #(.DATA_W(256), .MAX_BURST(4)) bus ();

  main_memory_burst #(
    .DATA_W    (256),
    .DEPTH     (16),
    .REGION_ID (MAIN_MEM_EN),
    .MAX_BURST (4)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: DUT updates on the falling edge, so sample on the rising edge
  always @(posedge Clk) begin
    logic [255:0] e;
    if (nReset === 1'b1 && bus.DataValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got DataValid=1 with data %h expected no beat", bus.Dataout);
      end else begin
        e = exp_q.pop_front();
        check("read_beat", bus.Dataout, e);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.nRead    = 1'b1;
    bus.nWrite   = 1'b1;
    bus.address  = {REG, 12'h000};
    bus.BurstLen = '0;
    bus.DataIn   = '0;
  endtask

  // One-cycle request, then release the strobes
  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [1:0] len, input logic [255:0] d);
    bus.nRead    = !rd;
    bus.nWrite   = !wr;
    bus.address  = a;
    bus.BurstLen = len;
    bus.DataIn   = d;
    cyc();
    idle_bus();
  endtask

  initial begin
    idle_bus();
    nReset = 1'b0;
    cyc();
    cyc();
    check("rst_dout",  bus.Dataout,   256'h0);
    check("rst_valid", bus.DataValid, 1'b0);
    check("rst_busy",  bus.Busy,      1'b0);
    check("rst_err",   bus.AddrErr,   1'b0);
    nReset = 1'b1;
    cyc();

    // Single read of image entry 10
    exp_q.push_back(256'h6);
    req(1'b1, 1'b0, 16'h200A, 2'd0, '0);
    check("single_busy", bus.Busy, 1'b0);
    cyc();
    check("valid_one_cycle", bus.DataValid, 1'b0);
    check("dout_hold", bus.Dataout, 256'h6);

    // Four-beat write burst wrapping 14,15,0,1
    bus.nWrite = 1'b0; bus.address = 16'h200E; bus.BurstLen = 2'd3; bus.DataIn = WA;
    cyc();
    check("wr_busy_1", bus.Busy, 1'b1);
    bus.nWrite = 1'b1; bus.DataIn = WB;
    cyc();
    check("wr_busy_2", bus.Busy, 1'b1);
    bus.DataIn = WC;
    cyc();
    check("wr_busy_3", bus.Busy, 1'b1);
    bus.DataIn = WD;
    cyc();
    check("wr_busy_end", bus.Busy, 1'b0);
    idle_bus();

    // Read burst back; a write to entry 10 presented while Busy is ignored
    exp_q.push_back(WA); exp_q.push_back(WB); exp_q.push_back(WC); exp_q.push_back(WD);
    bus.nRead = 1'b0; bus.address = 16'h200E; bus.BurstLen = 2'd3;
    cyc();
    check("rd_busy", bus.Busy, 1'b1);
    bus.nRead = 1'b1; bus.nWrite = 1'b0; bus.address = 16'h200A;
    bus.BurstLen = 2'd0; bus.DataIn = 256'hBAD;
    cyc();
    cyc();
    cyc();
    check("rd_busy_end", bus.Busy, 1'b0);
    idle_bus();
    exp_q.push_back(256'h6);
    req(1'b1, 1'b0, 16'h200A, 2'd0, '0);

    // Region mismatch: read gives no beat, write leaves entry 11 alone
    req(1'b1, 1'b0, 16'h300A, 2'd0, '0);
    check("mismatch_valid", bus.DataValid, 1'b0);
    check("mismatch_dout", bus.Dataout, 256'h6);
    req(1'b0, 1'b1, 16'h300B, 2'd0, 256'hDEAD);
    check("mismatch_err", bus.AddrErr, 1'b0);

    // Out-of-range: first illegal index, then a far one; write must not alias
    req(1'b1, 1'b0, 16'h2010, 2'd0, '0);
    check("oor_err", bus.AddrErr, 1'b1);
    check("oor_valid", bus.DataValid, 1'b0);
    check("oor_dout", bus.Dataout, 256'h6);
    cyc();
    check("oor_err_pulse", bus.AddrErr, 1'b0);
    req(1'b0, 1'b1, 16'h2010, 2'd0, 256'hBEEF);
    check("oor_wr_err", bus.AddrErr, 1'b1);
    req(1'b1, 1'b0, 16'h2FFF, 2'd0, '0);
    check("oor_top_err", bus.AddrErr, 1'b1);
    exp_q.push_back(WC);
    req(1'b1, 1'b0, 16'h2000, 2'd0, '0);

    // Read-modify-write; BurstLen is ignored so entry 12 stays at its image 0
    exp_q.push_back(256'hd);
    req(1'b1, 1'b1, 16'h200B, 2'd3, 256'h55);
    check("rmw_busy", bus.Busy, 1'b0);
    exp_q.push_back(256'h55);
    req(1'b1, 1'b0, 16'h200B, 2'd0, '0);
    exp_q.push_back(256'h0);
    req(1'b1, 1'b0, 16'h200C, 2'd0, '0);

    // Reset during beat 2 of a write burst at 2
    bus.nWrite = 1'b0; bus.address = 16'h2002; bus.BurstLen = 2'd3; bus.DataIn = 256'h111;
    cyc();
    bus.nWrite = 1'b1; bus.DataIn = 256'h222;
    cyc();
    nReset = 1'b0;
    #1;
    check("midrst_busy", bus.Busy, 1'b0);
    check("midrst_valid", bus.DataValid, 1'b0);
    check("midrst_dout", bus.Dataout, 256'h0);
    cyc();
    nReset = 1'b1;
    idle_bus();
    cyc();
    exp_q.push_back(MAT_A); exp_q.push_back(MAT_B);
    exp_q.push_back(256'h0); exp_q.push_back(256'h0);
    req(1'b1, 1'b0, 16'h2000, 2'd3, '0);

    // Drain outstanding beats with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
    end
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
